// File: rtl/conv_stream_ctrl_if.sv
// Handshake/bus bundle for conv_stream_ctrl.
//   rx_valid/rx_data           : receive strobe and pixel (UART rx -> ctrl)
//   arr_pix/arr_en/arr_pix_ok  : pixel, enable and window-valid to the 3x3 array
//   arr_pix_out                : array result (array -> ctrl)
//   tx_valid/tx_data/tx_ready  : result hold register ready/valid (ctrl -> UART tx)
// master = controller side, slave = surrounding datapath side.
interface conv_stream_ctrl_if;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic [7:0] arr_pix;
  logic       arr_en;
  logic       arr_pix_ok;
  logic [7:0] arr_pix_out;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;

  modport master (
    input  rx_valid, rx_data, arr_pix_out, tx_ready,
    output arr_pix, arr_en, arr_pix_ok, tx_valid, tx_data
  );

  modport slave (
    output rx_valid, rx_data, arr_pix_out, tx_ready,
    input  arr_pix, arr_en, arr_pix_ok, tx_valid, tx_data
  );
endinterface

// File: rtl/conv_stream_ctrl.sv
// Frame sequencer between UART rx, the 3x3 convolution window array and UART tx.
// One array enable per received pixel, LAT flush enables at end of frame, and
// exactly one result per pixel returned through a one-entry hold register.
// Ports:
//   clk        : system clock
//   rst        : asynchronous active-low reset
//   start      : one-cycle pulse, begins a frame when idle
//   bus        : rx / array / tx handshake bundle (conv_stream_ctrl_if.master)
//   busy       : high in every state except IDLE
//   frame_done : one-cycle pulse on DRAIN->IDLE
//   overrun    : sticky error, cleared by reset or start
module conv_stream_ctrl #(
  parameter int IMG_W = 99,
  parameter int IMG_H = 99,
  parameter int LAT   = 2,
  parameter int CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  conv_stream_ctrl_if.master         bus,
  output logic                       busy,
  output logic                       frame_done,
  output logic                       overrun
);

  localparam logic [CNT_W-1:0] NPIX    = CNT_W'(IMG_W * IMG_H);
  localparam logic [CNT_W-1:0] LAST_IN = CNT_W'(IMG_W * IMG_H - 1);
  localparam logic [CNT_W-1:0] OK_TH   = CNT_W'(2 * IMG_W + 2);
  localparam logic [CNT_W-1:0] CAP_END = CNT_W'(IMG_W * IMG_H + LAT);
  localparam logic [CNT_W-1:0] LAT_C   = CNT_W'(LAT);
  localparam logic [CNT_W-1:0] FL_LAST = CNT_W'(LAT - 1);

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_FLUSH, S_DRAIN} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] in_idx_q, in_idx_d;
  logic [CNT_W-1:0] out_idx_q, out_idx_d;
  logic [CNT_W-1:0] cap_idx_q, cap_idx_d;
  logic [CNT_W-1:0] fl_cnt_q, fl_cnt_d;
  logic [7:0]       arr_pix_q, arr_pix_d;
  logic             arr_en_q, arr_en_d;
  logic             arr_ok_q, arr_ok_d;
  logic             cap_q, cap_d;
  logic             tx_valid_q, tx_valid_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             overrun_q, overrun_d;
  logic             frame_done_q, frame_done_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      in_idx_q     <= '0;
      out_idx_q    <= '0;
      cap_idx_q    <= '0;
      fl_cnt_q     <= '0;
      arr_pix_q    <= '0;
      arr_en_q     <= 1'b0;
      arr_ok_q     <= 1'b0;
      cap_q        <= 1'b0;
      tx_valid_q   <= 1'b0;
      tx_data_q    <= '0;
      overrun_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      in_idx_q     <= in_idx_d;
      out_idx_q    <= out_idx_d;
      cap_idx_q    <= cap_idx_d;
      fl_cnt_q     <= fl_cnt_d;
      arr_pix_q    <= arr_pix_d;
      arr_en_q     <= arr_en_d;
      arr_ok_q     <= arr_ok_d;
      cap_q        <= cap_d;
      tx_valid_q   <= tx_valid_d;
      tx_data_q    <= tx_data_d;
      overrun_q    <= overrun_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    in_idx_d     = in_idx_q;
    out_idx_d    = out_idx_q;
    cap_idx_d    = cap_idx_q;
    fl_cnt_d     = fl_cnt_q;
    arr_pix_d    = '0;
    arr_en_d     = 1'b0;
    arr_ok_d     = 1'b0;
    cap_d        = arr_en_q;
    tx_valid_d   = tx_valid_q;
    tx_data_d    = tx_data_q;
    overrun_d    = overrun_q;
    frame_done_d = 1'b0;

    // Hold register: accept first, then a capture may reload in the same cycle.
    if (tx_valid_q && bus.tx_ready) tx_valid_d = 1'b0;
    if (cap_q) begin
      cap_idx_d = cap_idx_q + 1'b1;
      // The first LAT captures are pipeline fill and carry no result.
      if (cap_idx_q >= LAT_C && out_idx_q != NPIX) begin
        if (!tx_valid_q || bus.tx_ready) begin
          tx_data_d  = bus.arr_pix_out;
          tx_valid_d = 1'b1;
          out_idx_d  = out_idx_q + 1'b1;
        end else begin
          overrun_d = 1'b1;
        end
      end
    end

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_STREAM;
          in_idx_d  = '0;
          out_idx_d = '0;
          cap_idx_d = '0;
          fl_cnt_d  = '0;
          overrun_d = 1'b0;
        end
      end
      S_STREAM: begin
        if (bus.rx_valid) begin
          arr_en_d  = 1'b1;
          arr_pix_d = bus.rx_data;
          arr_ok_d  = (in_idx_q >= OK_TH);
          in_idx_d  = in_idx_q + 1'b1;
          if (in_idx_q == LAST_IN) state_d = S_FLUSH;
        end
      end
      S_FLUSH: begin
        arr_en_d = 1'b1;
        arr_ok_d = 1'b1;
        fl_cnt_d = fl_cnt_q + 1'b1;
        if (fl_cnt_q == FL_LAST) state_d = S_DRAIN;
        if (bus.rx_valid) overrun_d = 1'b1;
      end
      S_DRAIN: begin
        if (bus.rx_valid) overrun_d = 1'b1;
        // Flush results are still in flight on entry; wait for every capture
        // to land and the last one to be taken by the transmitter.
        if (cap_idx_q == CAP_END && !tx_valid_q) begin
          state_d      = S_IDLE;
          frame_done_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.arr_pix    = arr_pix_q;
  assign bus.arr_en     = arr_en_q;
  assign bus.arr_pix_ok = arr_ok_q;
  assign bus.tx_valid   = tx_valid_q;
  assign bus.tx_data    = tx_data_q;
  assign busy           = (state_q != S_IDLE);
  assign frame_done     = frame_done_q;
  assign overrun        = overrun_q;

endmodule

// File: tb/tb_conv_stream_ctrl.sv
// Directed bench for conv_stream_ctrl with a 4x3 frame and LAT=2.
// The array is modelled as a LAT+1 deep enable-shifted pipeline whose output
// is the pixel presented LAT enables earlier, XORed with 8'hA5.
module tb_conv_stream_ctrl;
  localparam int IMG_W = 4;
  localparam int IMG_H = 3;
  localparam int LAT   = 2;
  localparam int NPIX  = IMG_W * IMG_H;
  localparam int NEN   = NPIX + LAT;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic busy, frame_done, overrun;

  conv_stream_ctrl_if ifc ();

  conv_stream_ctrl #(.IMG_W(IMG_W), .IMG_H(IMG_H), .LAT(LAT), .CNT_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .bus        (ifc),
    .busy       (busy),
    .frame_done (frame_done),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  // Array model
  logic [7:0] mdl [0:LAT];
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i <= LAT; i++) mdl[i] <= '0;
    end else if (ifc.arr_en) begin
      for (int i = LAT; i > 0; i--) mdl[i] <= mdl[i-1];
      mdl[0] <= ifc.arr_pix;
    end
  end
  assign ifc.arr_pix_out = mdl[LAT] ^ 8'hA5;

  // Monitor, sampling on the falling edge
  int unsigned cyc = 0;
  int unsigned fd_cnt = 0;
  int unsigned bad_fd = 0;
  logic        prev_busy = 1'b0;
  logic        ok_q  [$];
  logic [7:0]  pix_q [$];
  int unsigned ecy_q [$];
  logic [7:0]  txd_q [$];

  always @(negedge clk) begin
    cyc++;
    if (ifc.arr_en) begin
      ok_q.push_back(ifc.arr_pix_ok);
      pix_q.push_back(ifc.arr_pix);
      ecy_q.push_back(cyc);
    end
    if (ifc.tx_valid && ifc.tx_ready) txd_q.push_back(ifc.tx_data);
    if (frame_done) begin
      fd_cnt++;
      if (busy || !prev_busy) bad_fd++;
    end
    prev_busy = busy;
  end

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q [$];
  int tx_base, en_base;
  int unsigned fd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_frame();
    exp_q.delete();
    tx_base = txd_q.size();
    en_base = ok_q.size();
    fd0 = fd_cnt;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic send_px(input logic [7:0] v, input bit rdy_pulse);
    exp_q.push_back(v ^ 8'hA5);
    ifc.rx_valid = 1'b1;
    ifc.rx_data  = v;
    step();
    ifc.rx_valid = 1'b0;
    step();
    if (rdy_pulse) ifc.tx_ready = 1'b1;
    step();
    if (rdy_pulse) ifc.tx_ready = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 200 && fd_cnt == fd0; i++) step();
    chk(tag, 32'(fd_cnt - fd0), 32'd1);
  endtask

  task automatic check_frame(input string tag);
    logic [13:0] okv;
    okv = '0;
    chk({tag, "_en_cnt"}, 32'(ok_q.size() - en_base), 32'(NEN));
    for (int i = 0; i < NEN; i++)
      if (en_base + i < ok_q.size()) okv[i] = ok_q[en_base + i];
    chk({tag, "_ok_pat"}, 32'(okv), 32'h3C00);
    if (en_base + NEN <= ok_q.size()) begin
      chk({tag, "_last_pix"}, 32'(pix_q[en_base + NPIX - 1]), 32'(exp_q[NPIX - 1] ^ 8'hA5));
      chk({tag, "_flush_pix"}, 32'(pix_q[en_base + NPIX]), 32'h0);
      chk({tag, "_flush_adj"}, ecy_q[en_base + NEN - 1] - ecy_q[en_base + NEN - 2], 32'd1);
    end
    chk({tag, "_tx_cnt"}, 32'(txd_q.size() - tx_base), 32'(NPIX));
    for (int i = 0; i < NPIX; i++)
      if (tx_base + i < txd_q.size())
        chk($sformatf("%s_tx%0d", tag, i), 32'(txd_q[tx_base + i]), 32'(exp_q[i]));
  endtask

  function automatic logic [7:0] pv(input int base, input int i);
    return 8'((base + i * 7) & 255);
  endfunction

  initial begin
    ifc.rx_valid = 1'b0;
    ifc.rx_data  = '0;
    ifc.tx_ready = 1'b1;
    step(); step();
    chk("reset_outs", 32'({ifc.arr_pix, ifc.arr_en, ifc.arr_pix_ok, ifc.tx_valid,
                           ifc.tx_data, busy, frame_done, overrun}), 32'h0);
    rst = 1'b1;
    step();

    // Frame 1: nominal, tx always ready
    begin_frame();
    chk("busy_stream", 32'(busy), 32'd1);
    for (int i = 0; i < NPIX; i++) send_px(pv(16, i), 1'b0);
    wait_done("f1_done");
    check_frame("f1");
    chk("f1_fd_busy", bad_fd, 32'd0);
    chk("f1_overrun", 32'(overrun), 32'd0);

    // Frame 2: tx never ready during the frame
    ifc.tx_ready = 1'b0;
    begin_frame();
    for (int i = 0; i < NPIX; i++) begin
      send_px(pv(40, i), 1'b0);
      if (i == 2) begin
        chk("f2_hold_valid", 32'(ifc.tx_valid), 32'd1);
        chk("f2_ovr_after1", 32'(overrun), 32'd0);
      end
      if (i == 3) begin
        chk("f2_ovr_after2", 32'(overrun), 32'd1);
        chk("f2_hold_data", 32'(ifc.tx_data), 32'(exp_q[0]));
      end
    end
    repeat (10) step();
    chk("f2_drain_hold", 32'(fd_cnt - fd0), 32'd0);
    chk("f2_drain_busy", 32'(busy), 32'd1);
    chk("f2_drain_data", 32'(ifc.tx_data), 32'(exp_q[0]));
    ifc.tx_ready = 1'b1;
    wait_done("f2_done");
    chk("f2_tx_cnt", 32'(txd_q.size() - tx_base), 32'd1);
    if (tx_base < txd_q.size()) chk("f2_tx0", 32'(txd_q[tx_base]), 32'(exp_q[0]));

    // Frame 3: accept coincides with a capture
    ifc.tx_ready = 1'b0;
    begin_frame();
    chk("f3_ovr_clr", 32'(overrun), 32'd0);
    for (int i = 0; i < 3; i++) send_px(pv(90, i), 1'b0);
    send_px(pv(90, 3), 1'b1);
    chk("f3_coinc_valid", 32'(ifc.tx_valid), 32'd1);
    chk("f3_coinc_data", 32'(ifc.tx_data), 32'(exp_q[1]));
    chk("f3_coinc_ovr", 32'(overrun), 32'd0);
    ifc.tx_ready = 1'b1;
    for (int i = 4; i < NPIX; i++) send_px(pv(90, i), 1'b0);
    wait_done("f3_done");
    check_frame("f3");
    chk("f3_overrun", 32'(overrun), 32'd0);

    // rx_valid in IDLE: ignored
    en_base = ok_q.size();
    ifc.rx_valid = 1'b1;
    ifc.rx_data  = 8'h33;
    step();
    ifc.rx_valid = 1'b0;
    step(); step();
    chk("idle_rx_en", 32'(ok_q.size() - en_base), 32'd0);
    chk("idle_rx_ovr", 32'(overrun), 32'd0);

    // Frame 4: rx_valid during FLUSH
    begin_frame();
    for (int i = 0; i < NPIX - 1; i++) send_px(pv(130, i), 1'b0);
    exp_q.push_back(pv(130, NPIX - 1) ^ 8'hA5);
    ifc.rx_valid = 1'b1;
    ifc.rx_data  = pv(130, NPIX - 1);
    step();
    ifc.rx_data  = 8'h77;
    step();
    ifc.rx_valid = 1'b0;
    chk("flush_rx_ovr", 32'(overrun), 32'd1);
    wait_done("f4_done");
    check_frame("f4");

    // Asynchronous reset mid-frame
    begin_frame();
    for (int i = 0; i < 7; i++) send_px(pv(200, i), 1'b0);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_outs", 32'({ifc.arr_pix, ifc.arr_en, ifc.arr_pix_ok, ifc.tx_valid,
                               ifc.tx_data, busy, frame_done, overrun}), 32'h0);
    step(); step();
    rst = 1'b1;
    step();
    begin_frame();
    for (int i = 0; i < NPIX; i++) send_px(pv(60, i), 1'b0);
    wait_done("f5_done");
    check_frame("f5");

    // start during STREAM is ignored
    begin_frame();
    for (int i = 0; i < 5; i++) send_px(pv(11, i), 1'b0);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 5; i < NPIX; i++) send_px(pv(11, i), 1'b0);
    wait_done("f6_done");
    check_frame("f6");

    // Back-to-back frame, start one cycle after frame_done
    begin_frame();
    chk("b2b_busy", 32'(busy), 32'd1);
    for (int i = 0; i < NPIX; i++) send_px(pv(77, i), 1'b0);
    wait_done("f7_done");
    check_frame("f7");
    chk("f7_overrun", 32'(overrun), 32'd0);
    chk("all_fd_busy", bad_fd, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/conv_stream_ctrl.md
Name: conv_stream_ctrl

Overview:
- Frame-level sequencer between the UART receive path, the 3x3 convolution window array and the UART transmit path.
- Accepts one pixel per receive strobe and issues one array enable per pixel.
- Drives the array's "enough pixels" qualifier and flushes the array pipeline at end of frame.
- Returns exactly one processed pixel per input pixel to the transmitter through a one-entry hold register with a ready/valid handshake.

Parameters:
IMG_W, 99, pixels per image row (line stride of the window array)
IMG_H, 99, rows per frame
LAT, 2, number of array enables between presenting a pixel and its result appearing on arr_pix_out
CNT_W, 16, width of the pixel index counter; must satisfy 2^CNT_W > IMG_W*IMG_H+LAT

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
start  in  1  one-cycle pulse; begins a frame when the block is idle
rx_valid  in  1  one-cycle strobe; new pixel on rx_data
rx_data  in  8  received pixel
arr_pix  out  8  pixel presented to the array
arr_en  out  1  array enable, one-cycle pulse per presented pixel
arr_pix_ok  out  1  array window-valid qualifier, aligned with arr_en
arr_pix_out  in  8  array result, sampled the cycle after arr_en
tx_valid  out  1  result available in the hold register
tx_data  out  8  result byte
tx_ready  in  1  transmitter accepts tx_data when tx_valid & tx_ready
busy  out  1  high in every state except IDLE
frame_done  out  1  one-cycle pulse on the DRAIN->IDLE transition
overrun  out  1  sticky error flag; cleared only by reset or start

Behaviour:
- Reset (rst=0, asynchronous) applies immediately, including mid-frame: state=IDLE, all counters=0, and every output =0 (arr_pix, arr_en, arr_pix_ok, tx_valid, tx_data, busy, frame_done, overrun). A partial frame is abandoned, and the hold register contents are discarded.
- States: IDLE, STREAM, FLUSH, DRAIN.
- IDLE:
  - start -> STREAM; clear in_idx, out_idx and overrun.
  - rx_valid in IDLE is ignored.
- STREAM, on rx_valid:
  - Next cycle: arr_en=1, arr_pix=rx_data, arr_pix_ok=(in_idx >= 2*IMG_W+2); then in_idx++.
  - When in_idx reaches IMG_W*IMG_H-1 on that strobe -> FLUSH.
- FLUSH:
  - Issues LAT enables on consecutive cycles with arr_pix=0 and arr_pix_ok=1; then -> DRAIN.
  - rx_valid during FLUSH/DRAIN is dropped and sets overrun.
- DRAIN: waits for tx_valid=0, then pulses frame_done and returns to IDLE.
- start outside IDLE is ignored.
- arr_en is never high on two consecutive cycles in STREAM. In FLUSH it is high for exactly LAT consecutive cycles.
- Result capture, on the cycle after each arr_en:
  - cap_idx increments for every enable.
  - The first LAT captures of a frame are discarded (pipeline fill).
  - Each later capture loads arr_pix_out into the hold register, sets tx_valid=1 and increments out_idx.
  - Total results per frame = IMG_W*IMG_H exactly.
- Hold register:
  - tx_valid clears on tx_valid & tx_ready.
  - tx_data is stable while tx_valid=1.
  - Capture and accept in the same cycle: the new result loads and tx_valid stays 1 (no overrun).
  - Capture while tx_valid=1 and tx_ready=0: the new result is dropped, overrun=1, and the old data is kept.
- Boundary conditions:
  - rx_valid on the cycle STREAM is entered is accepted.
  - The last pixel strobe and the FLUSH entry do not lose the last pixel.
  - Counters never wrap within a frame; CNT_W is sized by parameter.
- busy=1 in STREAM, FLUSH and DRAIN.

Test Plan:
- IMG_W=4, IMG_H=3, LAT=2; reset, start, 12 rx_valid strobes spaced 3 cycles, tx_ready=1 -> 14 arr_en pulses (12 stream + 2 consecutive flush). arr_pix_ok low for pixel indices 0-9, high for 10, 11 and both flush enables. 12 tx handshakes. frame_done once; busy falls the same cycle.
- Same frame, tx_ready held 0 for the whole frame -> the first captured result is held unchanged on tx_data. overrun=1 after the second capture. DRAIN holds until tx_ready=1, then frame_done.
- Capture coincident with a tx accept (tx_ready=1 exactly on the capture cycle, tx_valid=1) -> the new byte replaces the old, tx_valid stays 1, overrun stays 0.
- rx_valid pulsed during FLUSH and during IDLE -> overrun=1 for the FLUSH case only. The array sees no extra enable in either case.
- Assert rst=0 asynchronously after pixel 6 -> all outputs 0 immediately with no clock edge. After release, start begins a clean frame with in_idx=0 and 12 results returned.
- start pulsed during STREAM -> ignored, with no counter reset. Back-to-back frames (start one cycle after frame_done) -> the second frame returns 12 results and overrun=0.
